serial_adder: RTL

- Parametrised multi-cycle successor to the single-bit half adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a registered carry between digits.
- Start/ready/done handshake; the result holds until the next operation.
- Used where area matters more than latency, e.g. in accumulators and address-step logic in the compute datapath.

---
 rtl/serial_adder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
`timescale 1ns/1ps

module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] suma,
  output logic             c_out,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW    = DIGIT + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DW-1:0]    dsum;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
  logic             msb_cin;
`endif

  // One digit of the addition: the low DIGIT bits of the operand shift registers.
  assign dsum = DW'(a_q[DIGIT-1:0]) + DW'(b_q[DIGIT-1:0]) + DW'(carry_q);
`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the top bit of the digit, recovered from sum = a ^ b ^ cin.
  assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
`endif

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            sum_d[i*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
          end
        end
        carry_d = dsum[DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
`ifdef SERIAL_ADDER_OVF_EN
        if (cnt_q == '0) begin
          ovf_d = 1'b0;
        end
`endif
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          cout_d  = dsum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = msb_cin ^ dsum[DIGIT];
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake flags are registered copies of the next-state decode.
    ready_d = (state_d != ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign suma  = sum_q;
  assign c_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule
